// File: rtl/ex_mul_unit.sv
// Iterative 32x32 unsigned shift-and-add multiplier for the EX stage.
// Detects R-type MUL/MULHU, stalls the front end while iterating, then emits a one-cycle result.
module ex_mul_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              RegWrite_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [9:0]        funct_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [4:0]        rd_addr_i,
    output logic              stall_o,
    output logic              result_valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic [4:0]        rd_addr_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_e                state_q,  state_d;
    logic [2*DATA_W-1:0]   mcand_q,  mcand_d;
    logic [DATA_W-1:0]     mplier_q, mplier_d;
    logic [2*DATA_W-1:0]   acc_q,    acc_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  hi_sel_q, hi_sel_d;
    logic [4:0]            rd_q,     rd_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic [4:0]            rd_out_q, rd_out_d;

    logic                  is_mul;
    logic [2*DATA_W-1:0]   acc_sum;

    assign is_mul = RegWrite_i && (ALUOp_i == 2'b10) && (funct_i[9:3] == 7'b0000001)
                    && ((funct_i[2:0] == 3'b000) || (funct_i[2:0] == 3'b011));

    // Partial product for the current multiplier bit; also feeds the final result on the last step.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // NOTE: every variable gets a hold default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        hi_sel_d = hi_sel_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (is_mul) begin
                        state_d  = ST_BUSY;
                        mcand_d  = {{DATA_W{1'b0}}, rs1_data_i};
                        mplier_d = rs2_data_i;
                        acc_d    = '0;
                        count_d  = '0;
                        hi_sel_d = funct_i[1];
                        rd_d     = rd_addr_i;
                    end
                end
                ST_BUSY: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        state_d  = ST_DONE;
                        result_d = hi_sel_q ? acc_sum[2*DATA_W-1:DATA_W] : acc_sum[DATA_W-1:0];
                        rd_out_d = rd_q;
                    end
                end
                ST_DONE: begin
                    // ID/EX still holds the completing instruction here, so is_mul is ignored.
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            hi_sel_q <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            hi_sel_q <= hi_sel_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    // Reset gating keeps the front end free while reset is held even if ID/EX shows a multiply.
    assign stall_o        = rst_n_i && !flush_i
                            && (((state_q == ST_IDLE) && is_mul) || (state_q == ST_BUSY));
    assign result_valid_o = (state_q == ST_DONE) && !flush_i;
    assign busy_o         = (state_q != ST_IDLE);
    assign result_o       = result_q;
    assign rd_addr_o      = rd_out_q;

endmodule
